// File: rtl/aes_key_mem_128.sv
// AES-128 key expansion memory: expands the cipher key into 11 round keys.
// Optional AES_KEY_ZEROIZE_EN clears the key memory when a new expansion starts.
module aes_key_mem_128 (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         init,
   input  logic [127:0] key,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic         ready,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw
);

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      GENERATE,
      DONE
   } state_t;

   state_t       state_q;
   state_t       state_d;
   logic [127:0] key_q;
   logic [127:0] prev_q;
   logic [127:0] next_key;
   logic [127:0] key_mem [0:10];
   logic [3:0]   cnt_q;
   logic [7:0]   rcon_q;
   logic         ready_q;
   logic         start;
   logic         load;
   logic         gen;
   logic         last;
   logic [31:0]  t;
   logic [31:0]  nw0;
   logic [31:0]  nw1;
   logic [31:0]  nw2;
   logic [31:0]  nw3;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      load    = 1'b0;
      gen     = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (init) begin
               start   = 1'b1;
               state_d = INIT;
            end
         end
         INIT: begin
            load    = 1'b1;
            state_d = GENERATE;
         end
         GENERATE: begin
            gen = 1'b1;
            if (cnt_q == 4'd10) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The previous round key lives in prev_q so the S-box path never reads key_mem.
   assign sboxw = {prev_q[23:0], prev_q[31:24]};
   assign t     = new_sboxw ^ {rcon_q, 24'h0};
   assign nw0   = prev_q[127:96] ^ t;
   assign nw1   = prev_q[95:64]  ^ nw0;
   assign nw2   = prev_q[63:32]  ^ nw1;
   assign nw3   = prev_q[31:0]   ^ nw2;
   assign next_key = {nw0, nw1, nw2, nw3};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q   <= '0;
         prev_q  <= '0;
         cnt_q   <= 4'd0;
         rcon_q  <= 8'h01;
         ready_q <= 1'b1;
         for (int i = 0; i < 11; i++) key_mem[i] <= '0;
      end else begin
         if (start) begin
            key_q   <= key;
            ready_q <= 1'b0;
            cnt_q   <= 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
            for (int i = 0; i < 11; i++) key_mem[i] <= '0;
`endif
         end
         if (load) begin
            key_mem[0] <= key_q;
            prev_q     <= key_q;
            cnt_q      <= 4'd1;
            rcon_q     <= 8'h01;
         end
         if (gen) begin
            for (int i = 1; i < 11; i++) begin
               if (cnt_q == 4'(i)) key_mem[i] <= next_key;
            end
            prev_q <= next_key;
            cnt_q  <= cnt_q + 4'd1;
            // Hold 8'h36 after the last round instead of stepping past it.
            if (!last) rcon_q <= xtime(rcon_q);
         end
         if (state_q == DONE) ready_q <= 1'b1;
      end
   end

   assign ready = ready_q;

   always_comb begin
      round_key = '0;
      for (int i = 0; i < 11; i++) begin
         if (round == 4'(i)) round_key = key_mem[i];
      end
   end

endmodule

// File: tb/tb_aes_key_mem_128.sv
// Randomized self-checking bench for aes_key_mem_128 against a
// word-level FIPS-197 key schedule model.
module tb_aes_key_mem_128;

   logic         clk;
   logic         reset_n;
   logic         init;
   logic [127:0] key;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         ready;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb [0:255];
   logic [7:0]   rc [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [127:0] exp_k [0:10];
   logic [127:0] mem_m [0:10];
   logic [127:0] r10_e5;

   localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   aes_key_mem_128 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .init      (init),
      .key       (key),
      .round     (round),
      .round_key (round_key),
      .ready     (ready),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw)
   );

   assign new_sboxw = {sb[sboxw[31:24]], sb[sboxw[23:16]],
                       sb[sboxw[15:8]],  sb[sboxw[7:0]]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] a;
      for (int x = 0; x < 256; x++) begin
         a   = 8'(x);
         inv = 8'h00;
         if (a != 8'h00) begin
            inv = 8'h01;
            for (int j = 0; j < 254; j++) inv = gmul(inv, a);
         end
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   task automatic expand(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0)
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc[i/4-1], 24'h0};
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++)
         exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic rd(input string tag, input int r, input logic [127:0] exp);
      round = 4'(r);
      #1;
      check(tag, round_key, exp);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 11; i++) mem_m[i] = '0;
   endtask

   task automatic run_expand(input logic [127:0] k, input bit reinit,
                             input bit dinit, output logic [127:0] r10);
      expand(k);
      r10 = 'x;
      @(negedge clk);
      init = 1'b1;
      key  = k;
      @(negedge clk);
      init = 1'b0;
      key  = rnd128();
`ifdef AES_KEY_ZEROIZE_EN
      clear_model();
`endif
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         if (e <= 11) mem_m[e-1] = exp_k[e-1];
         check("ready_seq", {127'h0, ready}, {127'h0, (e == 12)});
         if (e <= 11) begin
            rd("mid_new", e - 1, mem_m[e-1]);
            if (e < 11) rd("mid_old", e, mem_m[e]);
         end
         if (e == 5) begin
            round = 4'd10;
            #1;
            r10 = round_key;
         end
         init = (reinit && e == 2) || (dinit && e == 11);
         key  = rnd128();
      end
      init = 1'b0;
      if (dinit) begin
         @(negedge clk);
         check("done_init_ignored", {127'h0, ready}, 128'h1);
      end
      for (int r = 0; r < 11; r++) rd("final", r, mem_m[r]);
   endtask

   initial begin
      reset_n = 1'b0;
      init    = 1'b0;
      key     = '0;
      round   = 4'd0;
      build_sbox();
      clear_model();
      repeat (2) @(negedge clk);
      check("rst_ready", {127'h0, ready}, 128'h1);
      check("rst_sboxw", {96'h0, sboxw}, 128'h0);
      rd("rst_r0", 0, 128'h0);
      rd("rst_r10", 10, 128'h0);
      rd("rst_r15", 15, 128'h0);
      reset_n = 1'b1;

      run_expand(FIPS_K, 1'b0, 1'b0, r10_e5);
      rd("fips_r0", 0, FIPS_K);
      rd("fips_r1", 1, FIPS_R1);
      rd("fips_r10", 10, FIPS_R10);

      run_expand(128'h0, 1'b0, 1'b0, r10_e5);
`ifdef AES_KEY_ZEROIZE_EN
      check("zeroize_r10_e5", r10_e5, 128'h0);
`else
      check("retain_r10_e5", r10_e5, FIPS_R10);
`endif
      rd("zero_r0", 0, 128'h0);
      rd("zero_r1", 1, ZERO_R1);
      rd("zero_r10", 10, ZERO_R10);

      run_expand(FIPS_K, 1'b1, 1'b1, r10_e5);
      rd("reinit_r1", 1, FIPS_R1);
      rd("reinit_r10", 10, FIPS_R10);
      rd("range_r11", 11, 128'h0);
      rd("range_r15", 15, 128'h0);

      @(negedge clk);
      init = 1'b1;
      key  = rnd128();
      @(negedge clk);
      init = 1'b0;
      repeat (6) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("abort_ready_async", {127'h0, ready}, 128'h1);
      @(negedge clk);
      reset_n = 1'b1;
      clear_model();
      check("abort_ready", {127'h0, ready}, 128'h1);
      for (int r = 0; r < 11; r++) rd("abort_clear", r, 128'h0);

      repeat (4) run_expand(rnd128(), 1'b0, 1'b0, r10_e5);
      run_expand(rnd128(), 1'b1, 1'b1, r10_e5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_key_mem_128.md
AES_KEY_MEM_128 -- requirements
Module: aes_key_mem_128

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed below (clock and reset first).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 init  input  1  single-cycle request to start expanding key; honoured only while ready=1.
REQ-005 key  input  128  AES-128 cipher key, bits [127:96] = w0.
REQ-006 round  input  4  round-key index requested by the encipher datapath.
REQ-007 round_key  output  128  stored round key for index round.
REQ-008 ready  output  1  high when idle and all 11 round keys are valid.
REQ-009 sboxw  output  32  word sent to the shared S-box (four byte lanes).
REQ-010 new_sboxw  input  32  S-box substitution of sboxw, combinational, same cycle.

Function
REQ-011 FSM states SHALL be IDLE, INIT, GENERATE, DONE.
- IDLE, init=1 -> INIT: key registered, ready cleared, round counter set to 0.
- INIT -> GENERATE: key_mem[0] = registered key, counter = 1, rcon = 8'h01.
- GENERATE writes one key per cycle into key_mem[counter], counter+1, rcon = xtime(rcon) (left shift, XOR 8'h1b on carry).
- GENERATE, write of index 10 -> DONE.
- DONE -> IDLE with ready set.
REQ-012 Expansion SHALL be: t = SubWord(RotWord(prev.w3)) ^ {rcon,24'h0}; w0'=prev.w0^t; w1'=prev.w1^w0'; w2'=prev.w2^w1'; w3'=prev.w3^w2'.
REQ-013 sboxw SHALL be RotWord(prev.w3) = {w3[23:0], w3[31:24]} in every cycle; SubWord is taken from new_sboxw in the same cycle.
REQ-014 Latency: with init sampled at edge E0, key_mem[0] SHALL be written at E1, key_mem[10] at E11, and ready SHALL be 1 after E12.
REQ-015 init while ready=0 SHALL be ignored, with no restart and no key capture.
REQ-016 The key input SHALL be sampled only at the init edge; later key changes SHALL not affect the expansion in progress.
REQ-017 round_key SHALL be a combinational read of key_mem[round].
REQ-018 round 11..15 SHALL return 128'h0.
REQ-019 round_key reads during expansion SHALL return the current memory contents: new values for written indices, old values otherwise.
REQ-020 init asserted in the same cycle that DONE returns to IDLE SHALL be ignored; it is accepted from the next cycle in IDLE.
REQ-021 Only the rcon values 01,02,04,08,10,20,40,80,1b,36 SHALL be used; the rcon register does not wrap or overrun.

Reset
REQ-022 reset_n low SHALL asynchronously set: state=IDLE, ready=1, counter=0, rcon=8'h01, key register=0, all key_mem entries=0.
REQ-023 Reset during INIT or GENERATE SHALL abort expansion immediately; after release, round_key=0 for all indices and ready=1.

Configuration
REQ-024 With AES_KEY_ZEROIZE_EN defined, all 11 key_mem entries SHALL be cleared to 0 at the IDLE->INIT edge, so entries not yet regenerated read 0.
REQ-025 Without AES_KEY_ZEROIZE_EN, entries SHALL retain previous-key values until overwritten; all other behaviour is identical.

Verification
REQ-026 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse init -> ready after 12 edges; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-027 Key 0, pulse init -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e; round 0 = 0.
REQ-028 Pulse init again at E3 of an expansion, and change key after E0 -> ignored; the results equal the first key's FIPS vectors.
REQ-029 Drop reset_n at E6 of an expansion -> ready=1 and round 0..10 = 0 after release; a new init then completes normally.
REQ-030 round = 11 and round = 15 with all keys valid -> round_key = 0.
REQ-031 With and without AES_KEY_ZEROIZE_EN: expand the FIPS key, then init with the zero key and read round 10 at E5 -> 0 when defined, d014f9a8c9ee2589e13f0cc8b6630ca6 when undefined.
